// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: FSM state encoding, saturation limits and
// slice-count helpers used by the sequential subtractor.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_W = 64;

    // Most positive two's-complement value of a w-bit word, LSB-aligned in MAX_W bits
    function automatic logic [MAX_W-1:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 32'd1)) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 32'd1);
    endfunction

    function automatic int unsigned nslice(input int unsigned w, input int unsigned s);
        return w / s;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit adder. Every carry is formed from the group
// generate/propagate of the bits below it, so no carry waits on another.
module add_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cin_msb
);

    logic [SLICE-1:0] p_s;
    logic [SLICE-1:0] g_s;
    logic [SLICE:0]   c_s;

    assign p_s = x ^ y;
    assign g_s = x & y;

    // Lookahead carries: c[i+1] = G[i:0] | (P[i:0] & cin)
    always_comb begin
        logic gg_s;
        logic pp_s;
        gg_s   = 1'b0;
        pp_s   = 1'b1;
        c_s    = '0;
        c_s[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            gg_s       = g_s[i] | (p_s[i] & gg_s);
            pp_s       = pp_s & p_s[i];
            c_s[i + 1] = gg_s | (pp_s & cin);
        end
    end

    assign s       = p_s ^ c_s[SLICE-1:0];
    assign cout    = c_s[SLICE];
    assign cin_msb = c_s[SLICE-1];

endmodule

// File: rtl/sub_seq_sat.sv
// Slice-serial subtractor: a - b as a + ~b + 1, SLICE bits per cycle through a
// single add_slice, with optional saturation on signed overflow.
module sub_seq_sat
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned NSLICE = nslice(WIDTH, SLICE);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned ACC_W  = (NSLICE > 1) ? (WIDTH - SLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSLICE - 1);
    localparam logic [MAX_W-1:0] SAT_POS_L = sat_pos(WIDTH);
    localparam logic [MAX_W-1:0] SAT_NEG_L = sat_neg(WIDTH);

    if ((WIDTH % SLICE) != 0 || WIDTH > MAX_W) begin : g_bad_width
        $error("sub_seq_sat: WIDTH must be a multiple of SLICE and at most 64");
    end

    state_e           state_r, state_nx_s;
    logic [WIDTH-1:0] op_a_r, op_b_r;
    logic [ACC_W-1:0] acc_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r, ovfl_r, zero_r, neg_r;
    logic [SLICE-1:0] slice_s;
    logic             cout_s, cin_msb_s, ovfl_s;
    logic [WIDTH-1:0] raw_s, diff_nx_s;

    add_slice #(.SLICE(SLICE)) u_slice (
        .x       (op_a_r[SLICE-1:0]),
        .y       (op_b_r[SLICE-1:0]),
        .cin     (carry_r),
        .s       (slice_s),
        .cout    (cout_s),
        .cin_msb (cin_msb_s)
    );

    // Finished slices enter at the top of the accumulator and move down one slice per cycle
    if (NSLICE == 1) begin : g_one
        assign raw_s = slice_s;
    end else begin : g_many
        assign raw_s = {slice_s, acc_r};
    end

    // Final value; on the last slice op_a_r[SLICE-1] is still the original MSB of a
    always_comb begin
        ovfl_s = cin_msb_s ^ cout_s;
        if ((SAT == 1'b1) && ovfl_s) begin
            diff_nx_s = op_a_r[SLICE-1] ? SAT_NEG_L[WIDTH-1:0] : SAT_POS_L[WIDTH-1:0];
        end else begin
            diff_nx_s = raw_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = start_valid ? RUN : IDLE;
            RUN:     state_nx_s = (idx_r == LAST_IDX) ? DONE : RUN;
            DONE:    state_nx_s = res_ready ? IDLE : DONE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        start_ready = (state_r == IDLE);
        res_valid   = (state_r == DONE);
    end

    // Operand/result shift registers, slice index, borrow chain and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r   <= '0;
            op_b_r   <= '0;
            acc_r    <= '0;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            ovfl_r   <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        op_a_r  <= a;
                        op_b_r  <= ~b;
                        carry_r <= 1'b1;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    op_a_r  <= op_a_r >> SLICE;
                    op_b_r  <= op_b_r >> SLICE;
                    acc_r   <= ACC_W'(raw_s >> SLICE);
                    carry_r <= cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        diff_r   <= diff_nx_s;
                        borrow_r <= ~cout_s;
                        ovfl_r   <= ovfl_s;
                        zero_r   <= (diff_nx_s == '0);
                        neg_r    <= diff_nx_s[WIDTH-1];
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign diff   = diff_r;
    assign borrow = borrow_r;
    assign ovfl   = ovfl_r;
    assign zero   = zero_r;
    assign neg    = neg_r;

endmodule
